// File: rtl/print_arb_pkg.sv
// Shared types and constants for the two-requester print arbiter.
package print_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [7:0] CHAR_LF       = 8'h0A;
    localparam logic [7:0] CHAR_EOT      = 8'h04;

    // A message ends once one of these bytes has been written to the sink.
    function automatic logic is_terminator(input logic [7:0] b);
        return (b == CHAR_LF) || (b == CHAR_EOT);
    endfunction

endpackage

// File: rtl/print_arbiter_if.sv
// AHB-lite write-only master bus between the print arbiter and the sink.
interface print_arbiter_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;

    modport master (output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, input HREADY);
    modport slave  (input HADDR, HTRANS, HWRITE, HSIZE, HWDATA, output HREADY);
endinterface

// File: rtl/print_fifo.sv
// Synchronous FIFO with full/empty flags; read data is the current head.
module print_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/print_arbiter.sv
// Two requesters share one print sink; the owner keeps the bus for a whole
// message (up to LF/EOT) or until it goes quiet for IDLE_TIMEOUT cycles.
module print_arbiter
    import print_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          IDLE_TIMEOUT = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    print_arbiter_if.master bus,
    output logic [1:0] grant,
    output logic       busy
);
    logic [1:0]      valid, ready, push, pop, full, empty;
    logic [1:0][7:0] wdata, rdata;
    logic            live, rr_ptr, own, has_owner, owner_empty, owner_push;
    logic            addr_done, data_done, idle_tick, timeout, rel, do_grant;
    logic [1:0]      win;
    logic [7:0]      data_q, idle_cnt;
    state_t          state, state_nx;

    assign valid      = {req1_valid, req0_valid};
    assign wdata      = {req1_data, req0_data};
    // live holds ready low until the first edge after reset is released.
    assign ready      = {2{live}} & ~full;
    assign push       = valid & ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    for (genvar i = 0; i < 2; i++) begin : g_req
        print_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
            .HCLK(HCLK), .HRESET(HRESET),
            .push(push[i]), .wdata(wdata[i]),
            .pop(pop[i]), .rdata(rdata[i]),
            .full(full[i]), .empty(empty[i])
        );
    end

    assign own         = grant[1];
    assign has_owner   = |grant;
    assign owner_empty = empty[own];
    assign owner_push  = |(push & grant);
    assign addr_done   = (state == S_ADDR) && bus.HREADY;
    assign data_done   = (state == S_DATA) && bus.HREADY;
    assign pop         = {2{addr_done}} & grant;

    assign idle_tick = (state == S_IDLE) && has_owner && owner_empty;
    assign timeout   = idle_tick && !owner_push && (idle_cnt == 8'(IDLE_TIMEOUT - 1));
    assign rel       = (data_done && is_terminator(data_q)) || timeout;
    assign do_grant  = (state == S_IDLE) && !has_owner && (win != 2'b00);

    always_comb begin
        win = 2'b00;
        if (!empty[0] && !empty[1]) win = rr_ptr ? 2'b10 : 2'b01;
        else if (!empty[0])         win = 2'b01;
        else if (!empty[1])         win = 2'b10;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (has_owner && !owner_empty) state_nx = S_ADDR;
            S_ADDR:  if (bus.HREADY) state_nx = S_DATA;
            S_DATA:  if (bus.HREADY) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.HTRANS = HTRANS_IDLE;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        if (state == S_ADDR) begin
            bus.HTRANS = HTRANS_NONSEQ;
            bus.HADDR  = BASE_ADDR;
            bus.HWRITE = 1'b1;
        end
    end

    assign bus.HSIZE  = 3'b000;
    assign bus.HWDATA = {24'h0, data_q};
    assign busy       = (state != S_IDLE);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= S_IDLE;
            grant    <= 2'b00;
            rr_ptr   <= 1'b0;
            idle_cnt <= '0;
            data_q   <= '0;
            live     <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (addr_done) data_q <= rdata[own];
            // Release and grant are exclusive: a new owner is picked next idle cycle.
            if (rel) begin
                grant  <= 2'b00;
                rr_ptr <= ~own;
            end else if (do_grant) begin
                grant <= win;
            end
            if (rel || do_grant || owner_push) idle_cnt <= '0;
            else if (idle_tick)                idle_cnt <= idle_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_print_arbiter.sv
// Directed bench: scoreboard of expected (owner, byte) writes checked every cycle.
module tb_print_arbiter;
    import print_arb_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TMO  = 16;

    logic            HCLK = 1'b0;
    logic            HRESET = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0][7:0] req_data = '0;
    logic [1:0]      req_ready;
    logic [1:0]      grant;
    logic            busy;

    print_arbiter_if bus();

    print_arbiter #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .IDLE_TIMEOUT(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0_valid(req_valid[0]), .req0_data(req_data[0]), .req0_ready(req_ready[0]),
        .req1_valid(req_valid[1]), .req1_data(req_data[1]), .req1_ready(req_ready[1]),
        .bus(bus), .grant(grant), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct { bit src; logic [7:0] b; } exp_t;
    exp_t expq[$];
    int   acyc[$];
    int   n_done = 0;
    int   done_cyc = 0;
    bit   in_data = 0;
    bit   prev_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic expect_msg(input bit src, input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) expq.push_back('{src, bytes[8*i +: 8]});
    endtask

    // Compare process: bus protocol plus scoreboard at every data phase cycle.
    always @(negedge HCLK) begin
        if (HRESET) begin
            in_data    = 0;
            prev_stall = 0;
        end else begin
            chk("hsize", 32'(bus.HSIZE), 32'(0));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'(1));
            if (prev_stall) chk("addr_hold", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
            if (in_data) begin
                chk("htrans_data", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer: got %0h expected none", bus.HWDATA);
                end else begin
                    chk("hwdata", bus.HWDATA, {24'h0, expq[0].b});
                    if (bus.HREADY) begin
                        chk("owner", 32'(grant), 32'(expq[0].src ? 2'b10 : 2'b01));
                        expq.delete(0);
                    end
                end
                if (bus.HREADY) begin
                    in_data  = 0;
                    n_done++;
                    done_cyc = cyc;
                end
            end else if (bus.HTRANS == HTRANS_NONSEQ) begin
                chk("haddr", bus.HADDR, BASE);
                chk("hwrite", 32'(bus.HWRITE), 32'(1));
                chk("busy_addr", 32'(busy), 32'(1));
                if (bus.HREADY) begin
                    in_data = 1;
                    acyc.push_back(cyc);
                end
            end else begin
                chk("htrans_idle", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
                chk("hwrite_idle", 32'(bus.HWRITE), 32'(0));
            end
            prev_stall = (bus.HTRANS == HTRANS_NONSEQ) && !bus.HREADY;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push_str(input int r, input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            req_valid[r] = 1'b1;
            req_data[r]  = bytes[8*i +: 8];
            while (!req_ready[r] && w < 200) begin
                tick();
                w++;
            end
            if (w >= 200) fail_now("push_wait");
            tick();
        end
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((expq.size() != 0 || busy || grant != 2'b00) && w < 400) begin
            tick();
            w++;
        end
        chk(name, 32'(w < 400), 32'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 32'(bus.HTRANS), 32'(0));
        chk({tag, "_haddr"},  bus.HADDR, 32'(0));
        chk({tag, "_hwrite"}, 32'(bus.HWRITE), 32'(0));
        chk({tag, "_hwdata"}, bus.HWDATA, 32'(0));
        chk({tag, "_grant"},  32'(grant), 32'(0));
        chk({tag, "_busy"},   32'(busy), 32'(0));
        chk({tag, "_ready"},  32'(req_ready), 32'(0));
    endtask

    task automatic do_reset();
        req_valid = '0;
        HRESET = 1'b1;
        expq.delete();
        #1;
        chk_reset_outputs("rst");
        tick();
        tick();
        HRESET = 1'b0;
        tick();
        chk("ready_after_reset", 32'(req_ready), 32'(2'b11));
    endtask

    task automatic test_hi();
        acyc.delete();
        expect_msg(0, 40'h0A6948, 3);
        push_str(0, 40'h0A6948, 3);
        wait_drain("hi_drain");
        chk("hi_nwrites", 32'(acyc.size()), 32'(3));
        if (acyc.size() == 3) begin
            chk("hi_gap1", 32'(acyc[1] - acyc[0]), 32'(3));
            chk("hi_gap2", 32'(acyc[2] - acyc[1]), 32'(3));
        end
        chk("hi_grant_end", 32'(grant), 32'(0));
    endtask

    task automatic test_both();
        do_reset();
        expect_msg(0, 40'h0A41, 2);
        expect_msg(1, 40'h0A42, 2);
        fork
            push_str(0, 40'h0A41, 2);
            push_str(1, 40'h0A42, 2);
        join
        wait_drain("both_drain");
    endtask

    task automatic test_stall();
        int w, n0;
        n0 = n_done;
        bus.HREADY = 1'b0;
        expect_msg(0, 40'h0A005A, 3);
        push_str(0, 40'h0A005A, 3);
        w = 0;
        while (bus.HTRANS != HTRANS_NONSEQ && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) fail_now("stall_nonseq");
        repeat (4) tick();
        chk("stall_addr_busy", 32'(busy), 32'(1));
        bus.HREADY = 1'b1;
        tick();
        bus.HREADY = 1'b0;
        chk("stall_data_phase", 32'({busy, bus.HTRANS}), 32'({1'b1, HTRANS_IDLE}));
        repeat (4) tick();
        bus.HREADY = 1'b1;
        wait_drain("stall_drain");
        chk("stall_ntransfers", 32'(n_done - n0), 32'(3));
    endtask

    task automatic test_timeout();
        int w, g;
        logic [1:0] pg;
        expect_msg(1, 40'h43, 1);
        push_str(1, 40'h43, 1);
        w = 0;
        while (grant != 2'b10 && w < 50) begin
            tick();
            w++;
        end
        chk("tmo_req1_grant", 32'(grant), 32'(2'b10));
        expect_msg(0, 40'h0A51, 2);
        push_str(0, 40'h0A51, 2);
        g  = -1;
        pg = grant;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (grant == 2'b01) begin
                g = cyc;
                break;
            end
            pg = grant;
        end
        chk("tmo_gap_grant", 32'(pg), 32'(0));
        chk("tmo_latency", 32'(g - done_cyc), 32'(TMO + 2));
        wait_drain("tmo_drain");
    endtask

    task automatic test_backpressure();
        int acc, w;
        logic [39:0] b5;
        logic took;
        b5 = 40'h0A34333231;
        acc = 0;
        bus.HREADY = 1'b0;
        expect_msg(0, b5, 5);
        req_valid[0] = 1'b1;
        req_data[0]  = b5[7:0];
        for (int c = 0; c < 8; c++) begin
            took = req_ready[0] && req_valid[0];
            tick();
            if (took) begin
                acc++;
                if (acc < 5) req_data[0] = b5[8*acc +: 8];
                else         req_valid[0] = 1'b0;
            end
        end
        chk("bp_accepted", 32'(acc), 32'(4));
        chk("bp_ready_low", 32'(req_ready[0]), 32'(0));
        bus.HREADY = 1'b1;
        w = 0;
        while (acc < 5 && w < 50) begin
            took = req_ready[0];
            tick();
            if (took) acc++;
            w++;
        end
        req_valid[0] = 1'b0;
        chk("bp_all_accepted", 32'(acc), 32'(5));
        wait_drain("bp_drain");
    endtask

    task automatic test_reset_mid();
        int w, n0;
        bus.HREADY = 1'b1;
        push_str(0, 40'h0A5352, 3);
        w = 0;
        while (!(busy && bus.HTRANS == HTRANS_IDLE) && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) fail_now("rm_find_data");
        HRESET = 1'b1;
        #1;
        chk_reset_outputs("rm");
        n0 = n_done;
        expq.delete();
        tick();
        tick();
        HRESET = 1'b0;
        tick();
        chk("rm_ready_after", 32'(req_ready), 32'(2'b11));
        repeat (20) tick();
        chk("rm_no_stale", 32'(n_done - n0), 32'(0));
        chk("rm_grant_idle", 32'(grant), 32'(0));
    endtask

    initial begin
        bus.HREADY = 1'b1;
        do_reset();
        test_hi();
        test_both();
        test_stall();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
